booth_mul_r4: RTL
=================

Name: booth_mul_r4

Overview:
Sequential radix-4 Booth mantissa multiplier. It is the callee that answers the FPU multiply controller's Multi_valid/Multi_ack request.
- Takes two unsigned WIDTH-bit mantissas (hidden bit included) and returns the 2*WIDTH-bit unsigned product.
- Returns a 3-bit exception code.
- Iterative datapath: one Booth digit per clock, trading latency for area.

Parameters:
- WIDTH, 24, operand width in bits. Must be even and at least 4. Derived: ITER = (WIDTH+2)/2 = 13 Booth digits at default.

Ports:
- CLK  in  1  clock, rising edge
- RSTn  in  1  reset, asynchronous, active-low
- Multi_datain1  in  WIDTH  multiplicand (unsigned mantissa)
- Multi_datain2  in  WIDTH  multiplier (unsigned mantissa)
- Multi_valid  in  1  request; operands valid while high
- Multi_dataout  out  2*WIDTH  product; registered, held until next capture
- Multi_ack  out  1  one-cycle registered pulse; product and Multi_Exc valid in the same cycle
- Multi_Exc  out  3  000 = ok, 110 = protocol error (operands changed while busy)

Behaviour:
- Reset (RSTn=0, any time, including mid-operation): immediately clears all state.
  - State goes to IDLE.
  - Multi_ack=0, Multi_dataout=0, Multi_Exc=000; accumulator and counter cleared.
- States: IDLE, CALC, DONE, RELEASE.
- IDLE: when Multi_valid=1 is sampled:
  - Capture op A = {2'b00, Multi_datain1} and op B = {2'b00, Multi_datain2}; both are (WIDTH+2)-bit, zero-extended so they stay non-negative.
  - Clear accumulator P, set the appended Booth bit q(-1)=0, set cnt=0, Multi_Exc=000; go to CALC.
- CALC: one Booth digit per clock, taken from the LSB 3 bits {B[1], B[0], q(-1)}:
  - Digit mapping: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
  - Add the digit multiple to the upper (WIDTH+4) bits of P in two's complement.
  - Arithmetic-shift the combined {P, B, q(-1)} right by 2.
  - cnt increments each cycle; at cnt == ITER-1 the last digit is applied and the state goes to DONE.
- Result load: on the CALC->DONE edge, Multi_dataout is loaded with the low 2*WIDTH bits of the final product. The sign bit is guaranteed 0.
- Latency: Multi_ack is high in the cycle following edge number ITER+1 (14 at default), counting the IDLE capture edge as edge 1.
- DONE: Multi_ack=1 for exactly one cycle, then go to RELEASE.
  - The controller samples Multi_dataout and Multi_Exc combinationally during this cycle.
- RELEASE: Multi_ack=0; wait for Multi_valid=0, then go to IDLE.
  - The controller's registered valid drops one cycle after ack. A still-high valid in that cycle must NOT start a new multiply.
- Protocol check: in CALC, if Multi_valid=0 or either operand differs from its captured value:
  - Set Multi_Exc=110 (sticky until next capture); the computation continues; the ack is still produced.
- Hold rule: Multi_dataout is stable from DONE until the next IDLE capture.
- Simultaneous events: a reset asserted during the DONE cycle takes priority; the ack is suppressed.

Optional Feature:
- Macro BOOTH_MUL_EARLY_ZERO_EN.
- Defined: if either captured operand is 0:
  - IDLE goes directly to DONE with Multi_dataout=0 and Multi_Exc=000.
  - Multi_ack appears in the cycle after capture.
- Undefined: every operand pair takes the full ITER-cycle CALC path. The result is still 0.

Test Plan:
- 0x800000 x 0x800000 -> Multi_dataout=0x400000000000, Multi_Exc=000. Ack at cycle 14, exactly one cycle wide.
- 0xFFFFFF x 0xFFFFFF -> 0xFFFFFE000001. Also 0xC00000 x 0xA00000 -> 0x780000000000.
- Controller-style handshake with valid held one cycle past ack -> no second ack. After valid=0 then a new request, a second product is correct.
- 0x000000 x 0xABCDEF -> product 0.
  - With BOOTH_MUL_EARLY_ZERO_EN: ack 1 cycle after capture.
  - Without: ack at cycle 14.
- Change Multi_datain1 in cycle 5 of CALC -> Multi_Exc=110 at ack. The product equals that of the captured operands.
- RSTn pulsed low at CALC cycle 7 -> outputs 0 immediately with no ack. The next request completes normally with the correct product.

Source files
------------

// File: rtl/booth_mul_r4_if.sv
// Request/response bundle between the FPU multiply controller (master)
// and the radix-4 Booth mantissa multiplier (slave).
interface booth_mul_r4_if #(
  parameter int WIDTH = 24
);
  logic [WIDTH-1:0]   Multi_datain1;
  logic [WIDTH-1:0]   Multi_datain2;
  logic               Multi_valid;
  logic [2*WIDTH-1:0] Multi_dataout;
  logic               Multi_ack;
  logic [2:0]         Multi_Exc;

  modport master (
    output Multi_datain1, Multi_datain2, Multi_valid,
    input  Multi_dataout, Multi_ack, Multi_Exc
  );

  modport slave (
    input  Multi_datain1, Multi_datain2, Multi_valid,
    output Multi_dataout, Multi_ack, Multi_Exc
  );
endinterface

// File: rtl/booth_mul_r4.sv
// Sequential radix-4 Booth mantissa multiplier, one Booth digit per clock.
// Optional BOOTH_MUL_EARLY_ZERO_EN: a zero operand skips CALC and acks next cycle.
//
// state   | meaning
// IDLE    | waiting for Multi_valid, captures operands
// CALC    | applying one Booth digit per clock, checking operands stay put
// DONE    | one-cycle Multi_ack with product and exception code valid
// RELEASE | waiting for Multi_valid to drop before accepting a new request
module booth_mul_r4 #(
  parameter int WIDTH = 24
) (
  input  logic          CLK,
  input  logic          RSTn,
  booth_mul_r4_if.slave mul
);

  localparam int OPW  = WIDTH + 2;
  localparam int PW   = WIDTH + 4;
  localparam int ITER = (WIDTH + 2) / 2;
  localparam int CW   = $clog2(ITER);

  localparam logic [CW-1:0] CNT_LAST = CW'(ITER - 1);
  localparam logic [2:0]    EXC_OK   = 3'b000;
  localparam logic [2:0]    EXC_PROT = 3'b110;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CALC    = 2'd1;
  localparam logic [1:0] S_DONE    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  logic [1:0]         state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   bcap_q, bcap_d;
  logic [OPW-1:0]     b_q, b_d;
  logic [PW-1:0]      p_q, p_d;
  logic               qm1_q, qm1_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] dout_q, dout_d;
  logic               ack_q, ack_d;
  logic [2:0]         exc_q, exc_d;

  logic [PW-1:0]  a_ext, a_dbl, mult, sum, p_step;
  logic [OPW-1:0] b_step;
  logic           op_bad;

  // Booth digit selection, accumulate into the upper bits, then shift {P,B,q} right by 2
  always_comb begin
    a_ext = {4'b0000, a_q};
    a_dbl = {a_ext[PW-2:0], 1'b0};
    case ({b_q[1:0], qm1_q})
      3'b001, 3'b010: mult = a_ext;
      3'b011:         mult = a_dbl;
      3'b100:         mult = -a_dbl;
      3'b101, 3'b110: mult = -a_ext;
      default:        mult = '0;
    endcase
    sum    = p_q + mult;
    p_step = {{2{sum[PW-1]}}, sum[PW-1:2]};
    b_step = {sum[1:0], b_q[OPW-1:2]};
  end

  assign op_bad = !mul.Multi_valid
                  || (mul.Multi_datain1 != a_q)
                  || (mul.Multi_datain2 != bcap_q);

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    bcap_d  = bcap_q;
    b_d     = b_q;
    p_d     = p_q;
    qm1_d   = qm1_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    ack_d   = 1'b0;
    exc_d   = exc_q;
    case (state_q)
      S_IDLE: begin
        if (mul.Multi_valid) begin
          a_d     = mul.Multi_datain1;
          bcap_d  = mul.Multi_datain2;
          b_d     = {2'b00, mul.Multi_datain2};
          p_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = '0;
          exc_d   = EXC_OK;
          state_d = S_CALC;
`ifdef BOOTH_MUL_EARLY_ZERO_EN
          if ((mul.Multi_datain1 == '0) || (mul.Multi_datain2 == '0)) begin
            dout_d  = '0;
            ack_d   = 1'b1;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_CALC: begin
        p_d   = p_step;
        b_d   = b_step;
        qm1_d = b_q[1];
        cnt_d = cnt_q + CW'(1);
        if (op_bad) begin
          exc_d = EXC_PROT;
        end
        if (cnt_q == CNT_LAST) begin
          dout_d  = {p_step[WIDTH-3:0], b_step};
          ack_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_RELEASE;
      end
      S_RELEASE: begin
        if (!mul.Multi_valid) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      bcap_q  <= '0;
      b_q     <= '0;
      p_q     <= '0;
      qm1_q   <= 1'b0;
      cnt_q   <= '0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      exc_q   <= EXC_OK;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      bcap_q  <= bcap_d;
      b_q     <= b_d;
      p_q     <= p_d;
      qm1_q   <= qm1_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      ack_q   <= ack_d;
      exc_q   <= exc_d;
    end
  end

  assign mul.Multi_dataout = dout_q;
  assign mul.Multi_ack     = ack_q;
  assign mul.Multi_Exc     = exc_q;

endmodule
